// File: rtl/mod_add_sub_unit_pkg.sv
// mod_add_sub_unit_pkg: shared datapath width and op-select encoding
package mod_add_sub_unit_pkg;
  localparam int DATA_SIZE_ARB = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/mod_add_sub_unit_core.sv
// mod_addsub_core: combinational single-correction modular add and subtract, muxed by sel
module mod_addsub_core
  import mod_add_sub_unit_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE_ARB
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W:0]   w_s;
  logic [DATA_W:0]   w_d;
  logic [DATA_W-1:0] w_add;
  logic [DATA_W-1:0] w_sub;
  always_comb begin
    w_s = {1'b0, a} + {1'b0, b};
    w_d = {1'b0, a} - {1'b0, b};
    // corrections are done in DATA_W bits; truncation makes the carry/borrow drop out
    w_add = (w_s >= {1'b0, q}) ? w_s[DATA_W-1:0] - q : w_s[DATA_W-1:0];
    w_sub = w_d[DATA_W] ? w_d[DATA_W-1:0] + q : w_d[DATA_W-1:0];
    result = (sel == OP_SUB) ? w_sub : w_add;
  end
endmodule

// File: rtl/mod_add_sub_unit.sv
// mod_add_sub_unit: registered modular adder/subtractor with async active-low reset
module mod_add_sub_unit
  import mod_add_sub_unit_pkg::*;
#(
  parameter int DATA_W = DATA_SIZE_ARB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] NTTin0,
  input  logic [DATA_W-1:0] NTTin1,
  output logic [DATA_W-1:0] out
);
  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] r_out;
  mod_addsub_core #(.DATA_W(DATA_W)) u_core (
    .sel    (sel),
    .q      (q),
    .a      (NTTin0),
    .b      (NTTin1),
    .result (w_res)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_out <= '0;
    else r_out <= w_res;
  assign out = r_out;
endmodule

// File: tb/tb_mod_add_sub_unit.sv
// tb_mod_add_sub_unit: directed and random checks of mod_add_sub_unit against an arithmetic model
module tb_mod_add_sub_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] q = 32'd251;
  logic [31:0] NTTin0 = 32'd100;
  logic [31:0] NTTin1 = 32'd200;
  logic [31:0] out;
  logic [31:0] prev = '0;
  int n_checks = 0;
  int n_fail = 0;
  mod_add_sub_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .q      (q),
    .NTTin0 (NTTin0),
    .NTTin1 (NTTin1),
    .out    (out)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic logic [31:0] model(bit s, longint a, longint b, longint m);
    longint r;
    if (!s) begin
      r = a + b;
      if (r >= m) r = r - m;
    end else begin
      r = a - b;
      if (r < 0) r = r + m;
    end
    return r[31:0];
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // drive one op, confirm out holds until the edge, then shows the new result
  task automatic op(string tag, bit s, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    sel = s;
    NTTin0 = a;
    NTTin1 = b;
    #1;
    check({tag, "_hold"}, out, prev);
    @(posedge clk);
    #1;
    check(tag, out, exp);
    check({tag, "_model"}, out, model(s, a, b, q));
    prev = exp;
  endtask
  initial begin
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", out, 32'd0);
    end
    reset = 1'b1;
    op("add_100_200", 1'b0, 32'd100, 32'd200, 32'd49);
    op("add_10_20", 1'b0, 32'd10, 32'd20, 32'd30);
    op("add_eq_q", 1'b0, 32'd125, 32'd126, 32'd0);
    op("add_250_250", 1'b0, 32'd250, 32'd250, 32'd249);
    op("sub_200_50", 1'b1, 32'd200, 32'd50, 32'd150);
    op("sub_5_10", 1'b1, 32'd5, 32'd10, 32'd246);
    op("sub_eq", 1'b1, 32'd77, 32'd77, 32'd0);
    op("sub_0_250", 1'b1, 32'd0, 32'd250, 32'd1);
    op("b2b_add0", 1'b0, 32'd100, 32'd200, 32'd49);
    op("b2b_sub0", 1'b1, 32'd5, 32'd10, 32'd246);
    op("b2b_add1", 1'b0, 32'd125, 32'd126, 32'd0);
    op("b2b_sub1", 1'b1, 32'd200, 32'd50, 32'd150);
    op("oor_add", 1'b0, 32'd16383, 32'd16383, 32'd32515);
    op("oor_sub", 1'b1, 32'd100, 32'd16383, 32'hFFFFC160);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", out, 32'd0);
    @(posedge clk);
    #1;
    check("reset_discard", out, 32'd0);
    reset = 1'b1;
    prev = '0;
    for (int i = 0; i < 40; i++) begin
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      s = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 250);
      b = $urandom_range(0, 250);
      op("random", s, a, b, model(s, a, b, 251));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_add_sub_unit.md
Name: mod_add_sub_unit

Overview:
Registered modular adder/subtractor for the NTT datapath. A select input chooses the operation:
- sel=0: (NTTin0 + NTTin1) mod q
- sel=1: (NTTin0 - NTTin1) mod q

It is the merged replacement for separate add and subtract butterflies. Result appears one clock after the operands.

Parameters:
- DATA_W, 32, width of q, operands and result (matches the codebase DATA_SIZE_ARB).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted at 0; clears the output register immediately.
- sel  input  1  operation select: 0 = modular add, 1 = modular subtract.
- q  input  DATA_W  modulus, unsigned, nonzero; may change any cycle.
- NTTin0  input  DATA_W  operand A, unsigned.
- NTTin1  input  DATA_W  operand B, unsigned.
- out  output  DATA_W  registered result.

Behaviour:
- Reset: while reset=0, out=0 asynchronously. First capture is at the first rising edge with reset=1.
- Latency: exactly 1 cycle.
  - sel, q, NTTin0 and NTTin1 are sampled together at rising edge N.
  - out shows the result from edge N until edge N+1.
  - No handshake; a new operation is accepted every cycle.
- Add path:
  - s = NTTin0 + NTTin1, computed in DATA_W+1 bits (no overflow loss).
  - If s >= q, result = s - q; else result = s.
  - Truncate to DATA_W bits.
- Subtract path:
  - d = NTTin0 - NTTin1, computed as a DATA_W+1-bit two's-complement value.
  - If d < 0, result = d + q; else result = d.
  - Truncate to DATA_W bits.
- Exactly one correction step on each path; no iterative or division-based reduction.
  - For operands in [0, q), the result is the exact canonical residue in [0, q).
  - For operands outside [0, q), the result is the single-correction value defined above, not a full reduction. Out-of-range inputs are well defined, never X.
- Boundaries:
  - Add with s == q gives 0.
  - Subtract with NTTin0 == NTTin1 gives 0.
  - Subtract with a negative difference wraps by +q.
- Only the selected path's result is registered. Both paths may be computed in parallel and muxed by sel before the register.
- Reset asserted mid-stream forces out=0 at once. The operation captured in that cycle is discarded.
- out is never X once reset has been applied, for any known inputs.

Decomposition:
- Shared package holds:
  - DATA_W default (the DATA_SIZE_ARB equivalent);
  - the op-select encoding constants: OP_ADD=1'b0, OP_SUB=1'b1.
- One natural sub-module, mod_addsub_core: purely combinational.
  - Inputs: sel, q, a, b. Output: result.
  - Holds both correction paths and the mux.
  - The top wraps it with the async-reset output register.

Test Plan:
- Reset: hold reset=0 with NTTin0=100, NTTin1=200, and toggle clk -> out stays 0. Assert reset=0 after a nonzero result -> out drops to 0 without waiting for a clock edge.
- Add, q=251:
  - 100+200 -> 49 one cycle later;
  - 10+20 -> 30;
  - 125+126 -> 0 (s == q boundary);
  - 250+250 -> 249.
- Subtract, q=251:
  - 200-50 -> 150;
  - 5-10 -> 246;
  - 77-77 -> 0;
  - 0-250 -> 1.
- Back-to-back ops, q=251, alternating sel every cycle (add 100+200, sub 5-10, add 125+126, sub 200-50) -> out sequence 49, 246, 0, 150, each lagging its inputs by exactly one cycle.
- Out-of-range operands, q=251:
  - add 16383+16383 -> 32515 (single correction);
  - sub 100-16383 -> (-16032) as DATA_W-bit two's complement, e.g. 0xFFFFC160 for DATA_W=32.
- Randomized: 32+ cycles of random sel and operands in [0, q) for q=251, checked each cycle against a model of the add/sub rules above -> zero mismatches.
